// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle for chunked_adder.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : adder side (drives in_ready, out_valid, sum, cout, ovf)
// Signals: in_valid/in_ready, a, b, cin, sub (request side);
//          out_valid/out_ready, sum, cout, ovf (result side).
interface chunked_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle WIDTH-bit adder/subtractor resolving CHUNK bits
// per clock, LSB chunk first, carry held in a register between chunks.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - chunked_adder_if.slave (in_valid/in_ready, a, b, cin, sub,
//           out_valid/out_ready, sum, cout, ovf)
// Optional feature: define CHUNKED_ADDER_SAT_EN to saturate sum on signed
// overflow (cout/ovf still reported unmodified). Default build wraps.
module chunked_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CHUNK = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   chunked_adder_if.slave bus
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bx_q, bx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] bx_sl;
   logic [CHUNK:0]   slice;
   logic             msb_cin;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      bx_d    = bx_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      a_sl    = '0;
      bx_sl   = '0;
      slice   = '0;
      msb_cin = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               // Subtract is a + ~b + ~borrow; cin doubles as borrow-in.
               a_d     = bus.a;
               bx_d    = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? ~bus.cin : bus.cin;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // Constant-index slice select keeps the part-selects static.
            for (int unsigned i = 0; i < N; i++) begin
               if (cnt_q == CW'(i)) begin
                  a_sl  = a_q[i*CHUNK +: CHUNK];
                  bx_sl = bx_q[i*CHUNK +: CHUNK];
               end
            end
            slice = {1'b0, a_sl} + {1'b0, bx_sl} + {{CHUNK{1'b0}}, carry_q};
            for (int unsigned i = 0; i < N; i++) begin
               if (cnt_q == CW'(i)) begin
                  sum_d[i*CHUNK +: CHUNK] = slice[CHUNK-1:0];
               end
            end
            carry_d = slice[CHUNK];
            if (cnt_q == CW'(N-1)) begin
               // Carry into the MSB recovered from the MSB's own sum bit.
               msb_cin = a_q[WIDTH-1] ^ bx_q[WIDTH-1] ^ slice[CHUNK-1];
               cout_d  = slice[CHUNK];
               ovf_d   = msb_cin ^ slice[CHUNK];
`ifdef CHUNKED_ADDER_SAT_EN
               if (ovf_d) begin
                  sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
               end
`else
`endif
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         bx_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed checks of chunked_adder at WIDTH=8/CHUNK=4 and a
// reference sweep at WIDTH=16/CHUNK=4.
module tb_chunked_adder;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

`ifdef CHUNKED_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   chunked_adder_if #(.WIDTH(8))  bus8 ();
   chunked_adder_if #(.WIDTH(16)) bus16 ();

   chunked_adder #(.WIDTH(8),  .CHUNK(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   chunked_adder #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start an 8-bit op from IDLE with out_ready low; return in DONE.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
      int lat;
      bus8.out_ready = 1'b0;
      bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
      bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 20) begin
         chk("busy_in_ready8", 32'(bus8.in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency8", lat, 2);
   endtask

   task automatic res8(input string tag, input logic [7:0] s, input logic co, input logic ov);
      chk({tag, "_valid"}, 32'(bus8.out_valid), 32'd1);
      chk({tag, "_sum"},   32'(bus8.sum),       32'(s));
      chk({tag, "_cout"},  32'(bus8.cout),      32'(co));
      chk({tag, "_ovf"},   32'(bus8.ovf),       32'(ov));
   endtask

   task automatic release8();
      bus8.in_valid  = 1'b0;
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("xfer_in_ready8",  32'(bus8.in_ready),  32'd1);
      chk("xfer_out_valid8", 32'(bus8.out_valid), 32'd0);
      bus8.out_ready = 1'b0;
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      int lat;
      int w;
      logic [16:0] r;
      logic [15:0] es;
      logic        ec, eo;
      w = 0;
      while (!bus16.in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      chk("wait_in_ready16", 32'(bus16.in_ready), 32'd1);
      bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
      bus16.in_valid = 1'b1;
      @(posedge clk); #1;
      bus16.in_valid = 1'b0;
      lat = 0;
      while (!bus16.out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency16", lat, 4);
      if (sub) begin
         r  = {1'b0, a} - {1'b0, b} - {16'd0, cin};
         es = r[15:0];
         ec = ~r[16];
         eo = (a[15] != b[15]) && (es[15] != a[15]);
      end else begin
         r  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         es = r[15:0];
         ec = r[16];
         eo = (a[15] == b[15]) && (es[15] != a[15]);
      end
      if (SAT && eo) es = a[15] ? 16'h8000 : 16'h7FFF;
      chk("sum16",  32'(bus16.sum),  32'(es));
      chk("cout16", 32'(bus16.cout), 32'(ec));
      chk("ovf16",  32'(bus16.ovf),  32'(eo));
      @(posedge clk); #1;
      chk("xfer_in_ready16", 32'(bus16.in_ready), 32'd1);
   endtask

   initial begin
      logic [32:0] kv;
      logic [7:0]  s_hold;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
      bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.sub = 1'b0;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
      bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("rst_in_ready",  32'(bus8.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("rst_sum",       32'(bus8.sum),       32'd0);
      chk("rst_cout",      32'(bus8.cout),      32'd0);
      chk("rst_ovf",       32'(bus8.ovf),       32'd0);
      chk("rst_sum16",     32'(bus16.sum),      32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // 200 + 100 = 0x12C
      op8(8'd200, 8'd100, 1'b0, 1'b0);
      res8("add", 8'h2C, 1'b1, 1'b0);

      // Backpressure: outputs frozen, inputs ignored.
      s_hold = 8'h2C;
      for (int i = 0; i < 10; i++) begin
         bus8.a = 8'($urandom); bus8.b = 8'($urandom);
         bus8.cin = 1'(i); bus8.sub = 1'(i >> 1);
         bus8.in_valid = ((i % 2) == 0);
         @(posedge clk); #1;
         chk("bp_out_valid", 32'(bus8.out_valid), 32'd1);
         chk("bp_in_ready",  32'(bus8.in_ready),  32'd0);
         chk("bp_sum",       32'(bus8.sum),       32'(s_hold));
         chk("bp_cout",      32'(bus8.cout),      32'd1);
         chk("bp_ovf",       32'(bus8.ovf),       32'd0);
      end
      release8();

      op8(8'd127, 8'd1, 1'b0, 1'b0);
      res8("ovf_pos", SAT ? 8'h7F : 8'h80, 1'b0, 1'b1);
      release8();

      op8(8'h80, 8'h80, 1'b0, 1'b0);
      res8("ovf_neg", SAT ? 8'h80 : 8'h00, 1'b1, 1'b1);
      release8();

      op8(8'd5, 8'd7, 1'b0, 1'b1);
      res8("sub_borrow", 8'hFE, 1'b0, 1'b0);
      release8();

      op8(8'd9, 8'd3, 1'b1, 1'b1);
      res8("sub_cin", 8'h05, 1'b1, 1'b0);
      release8();

      // 0x80 - 1: -128 - 1 overflows to +127.
      op8(8'h80, 8'h01, 1'b0, 1'b1);
      res8("sub_ovf", SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1);
      release8();

      // Asynchronous reset during BUSY, counter 0.
      bus8.a = 8'd50; bus8.b = 8'd60; bus8.cin = 1'b0; bus8.sub = 1'b0;
      bus8.in_valid = 1'b1;
      @(posedge clk); #2;
      bus8.in_valid = 1'b0;
      chk("pre_rst_busy", 32'(bus8.in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus8.out_valid), 32'd0);
      chk("arst_in_ready",  32'(bus8.in_ready),  32'd1);
      chk("arst_sum",       32'(bus8.sum),       32'd0);
      @(negedge clk); rst_n = 1'b1;
      bus8.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("post_rst_no_result", 32'(bus8.out_valid), 32'd0);
      end
      bus8.out_ready = 1'b0;

      // Sweep at WIDTH=16: {a,b,cin} = k.
      bus16.out_ready = 1'b1;
      for (int k = 5000; k < 7000; k++) begin
         kv = 33'(k);
         for (int s = 0; s < 2; s++) begin
            op16(kv[32:17], kv[16:1], kv[0], 1'(s));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/chunked_adder.md
# chunked_adder

Parametrised multi-cycle adder/subtractor with a valid/ready handshake on both sides. A WIDTH-bit operation is resolved CHUNK bits per clock, LSB chunk first, with the carry held in a register between chunks. It is the sequential, width-generic successor to the team's 8-bit combinational adder and keeps that adder's operand and result naming (a, b, cin, cout, sum). It sits between a producer and a consumer that both tolerate multi-cycle latency and backpressure.

## Interface
- WIDTH, default 8: operand and result width. Must be a positive multiple of CHUNK.
- CHUNK, default 4: bits resolved per cycle. N = WIDTH/CHUNK cycles per operation.
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst_n, input, 1: reset. It is asynchronous and active-low.
- in_valid, input, 1: operands are presented.
- in_ready, output, 1: the block can accept an operation.
- a, input, WIDTH: operand A.
- b, input, WIDTH: operand B.
- cin, input, 1: carry-in for add, or borrow-in for subtract.
- sub, input, 1: 0 selects a+b+cin; 1 selects a−b−cin.
- out_valid, output, 1: a result is held on the outputs.
- out_ready, input, 1: the consumer accepts the result.
- sum, output, WIDTH: the result.
- cout, output, 1: carry-out of the MSB. In subtract mode, 1 means no borrow.
- ovf, output, 1: two's-complement signed overflow.

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0. A chunk counter runs 0..N−1.
  - DONE: out_valid=1.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
  - Latch a and the effective operand bx = sub ? ~b : b.
  - Initialise the carry register to sub ? ~cin : cin.
  - Transition IDLE→BUSY with counter=0.
- BUSY, each edge:
  - Compute the CHUNK-bit slice `counter` as a_slice + bx_slice + carry.
  - Write that slice into the sum register and update the carry register.
  - When counter reaches N−1, go to DONE.
- In the final chunk, record the carry into the MSB. Then:
  - cout = final carry.
  - ovf = carry-into-MSB XOR carry-out-of-MSB.
- DONE: outputs hold stable until out_ready=1. On the edge with out_valid && out_ready, go to IDLE.
- Inputs a, b, cin and sub are ignored outside the accept edge. Changes during BUSY or DONE have no effect.
- in_valid in BUSY or DONE is not accepted and does not stall or corrupt the current operation.
- Arithmetic wraps modulo 2^WIDTH unless the configuration macro below is defined.
- sum, cout and ovf are registered outputs. In DONE they change only when the operation completes.

## Timing
- Reset values while rst_n=0 or after its deassertion: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, counter=0, carry=0.
- Reset asserted mid-BUSY or in DONE aborts the operation immediately. No result is ever presented for it.
- Latency: accept on edge E → out_valid=1 after edge E+N.
- With out_ready held high:
  - Result transfers on edge E+N+1.
  - in_ready=1 after that edge.
  - Next accept no earlier than E+N+2.
  - Peak throughput is one operation per N+2 cycles.
- out_ready asserted in IDLE or BUSY has no effect.
- in_ready and out_valid are never both 1.
- Degenerate case N=1 (CHUNK=WIDTH): BUSY lasts exactly one cycle.

## Configuration
- CHUNKED_ADDER_SAT_EN defined: on ovf=1, sum saturates.
  - Clamps to 2^(WIDTH−1)−1 if a[MSB]=0; clamps to −2^(WIDTH−1) if a[MSB]=1. Here a and bx share a sign whenever overflow occurs.
  - cout and ovf are still reported unmodified.
- CHUNKED_ADDER_SAT_EN undefined: sum wraps; ovf is still reported.

## Test plan
- Add, WIDTH=8, CHUNK=4: a=200, b=100, cin=0, sub=0 → after exactly 2 BUSY cycles, sum=44 (0x2C), cout=1, ovf=0.
- Signed overflow: a=127, b=1, sub=0 → cout=0, ovf=1.
  - Without the macro: sum=0x80.
  - With CHUNKED_ADDER_SAT_EN: sum=0x7F.
  - a=0x80, b=0x80 with the macro → sum=0x80, ovf=1.
- Subtract: a=5, b=7, cin=0, sub=1 → sum=0xFE, cout=0, ovf=0. Then a=9, b=3, cin=1, sub=1 → sum=5, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, sum/cout/ovf stable, in_ready=0.
  - Toggling a/b/in_valid during those cycles changes nothing.
  - Releasing out_ready → transfer on that edge, in_ready=1 next cycle.
- Reset mid-operation: drop rst_n asynchronously during BUSY counter=0 → out_valid=0, in_ready=1, sum=0 immediately. No spurious result after release.
- Sweep at WIDTH=16, CHUNK=4: drive {a,b,cin} = k for k = 5000..6999, both sub values, out_ready=1.
  - Each result equals the reference arithmetic.
  - out_valid rises exactly 4 cycles after accept.
